// File: rtl/riscv_mem_pkg.sv
// ----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared types and constants for the unified-memory port arbiter:
//   - state_e     : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   - OWN_IF/OWN_D: owner encoding of the in-flight transaction
//   - DEF_*       : default widths / timing
//   - bits_for()  : register width needed to hold a value (minimum 1)
// ----------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MEM_LATENCY  = 2;
    localparam int DEF_MAX_D_STREAK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Number of bits needed to represent v (always at least 1).
    function automatic int bits_for(input int v);
        int n;
        n = 1;
        while (n < 31 && (1 << n) <= v) n++;
        return n;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the data (D) and fetch (IF)
// requesters. D wins unless IF is waiting and D has already used up its
// streak allowance, in which case IF is forced through.
// Ports:
//   i_d_req, i_if_req : raw requests
//   i_streak          : consecutive D grants taken while IF was pending
//   o_grant_d/o_grant_if : one-hot (or none) grant
// ----------------------------------------------------------------------------
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
    parameter int SW           = 3
) (
    input  logic          i_d_req,
    input  logic          i_if_req,
    input  logic [SW-1:0] i_streak,
    output logic          o_grant_d,
    output logic          o_grant_if
);

    logic w_if_starved;

    assign w_if_starved = i_if_req && (i_streak == SW'(MAX_D_STREAK));
    assign o_grant_d    = i_d_req && !w_if_starved;
    assign o_grant_if   = i_if_req && !o_grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the instruction
// fetch (IF) and load/store (D) requesters. One transaction in flight at a
// time: accept in IDLE, strobe mem_en in ISSUE, count the memory latency in
// WAIT, pulse the owner's rvalid in RESP.
// Ports:
//   i_clk, i_rst (async, active low)
//   IF side : i_if_req, i_if_addr, o_if_ready, o_if_rvalid, o_if_rdata
//   D side  : i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
//             o_d_ready, o_d_rvalid, o_d_rdata
//   Memory  : o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
//             i_mem_rdata
//   o_busy  : a transaction is in flight
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_ready,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,

    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_be,
    output logic                o_d_ready,
    output logic                o_d_rvalid,
    output logic [DATA_W-1:0]   o_d_rdata,

    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic [DATA_W-1:0]   i_mem_rdata,

    output logic                o_busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int CW   = bits_for(MEM_LATENCY - 1);
    localparam int SW   = bits_for(MAX_D_STREAK);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [SW-1:0]       r_streak;

    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_idle;
    logic                w_grant_d;
    logic                w_grant_if;
    logic                w_acc_d;
    logic                w_acc_if;
    logic                w_last_wait;

    assign w_idle      = (r_state == IDLE);
    assign w_last_wait = (r_state == WAIT) && (r_cnt == '0);

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .SW           (SW)
    ) u_pick (
        .i_d_req    (i_d_req),
        .i_if_req   (i_if_req),
        .i_streak   (r_streak),
        .o_grant_d  (w_grant_d),
        .o_grant_if (w_grant_if)
    );

    // Grants are only visible in IDLE; requests at any other time are dropped.
    assign w_acc_d  = w_idle && w_grant_d;
    assign w_acc_if = w_idle && w_grant_if;

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_if_ready  = 1'b0;
        o_d_ready   = 1'b0;
        o_mem_en    = 1'b0;
        o_if_rvalid = 1'b0;
        o_d_rvalid  = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                o_busy     = 1'b0;
                o_if_ready = w_grant_if;
                o_d_ready  = w_grant_d;
                if (w_acc_d || w_acc_if) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                o_mem_en    = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) w_state_nxt = RESP;
            end
            RESP: begin
                o_if_rvalid = (r_owner == OWN_IF);
                o_d_rvalid  = (r_owner == OWN_D);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Latency counter: loaded in ISSUE so WAIT lasts exactly MEM_LATENCY
    // cycles, ending on the cycle mem_rdata is valid.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= CW'(MEM_LATENCY - 1);
        end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // D streak: only meaningful while IF is waiting, so a D grant with no
    // fetch pending restarts it rather than counting toward starvation.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_streak <= '0;
        end else if (w_acc_if) begin
            r_streak <= '0;
        end else if (w_acc_d) begin
            if (!i_if_req) begin
                r_streak <= '0;
            end else if (r_streak != SW'(MAX_D_STREAK)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request capture: requester inputs are not looked at after accept.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_acc_d) begin
            r_owner <= OWN_D;
            r_we    <= i_d_we;
            r_addr  <= i_d_addr;
            r_wdata <= i_d_wdata;
            r_be    <= i_d_be;
        end else if (w_acc_if) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_addr  <= i_if_addr;
            r_be    <= '1;
        end
    end

    // ------------------------------------------------------------------
    // Read data capture on the last WAIT cycle; stores leave d_rdata alone.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_last_wait) begin
            if (r_owner == OWN_IF) begin
                r_if_rdata <= i_mem_rdata;
            end else if (!r_we) begin
                r_d_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_be    = r_be;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam logic [31:0] GARB = 32'hBAD0_BAD0;

    typedef struct {
        logic        if_req;
        logic        d_req;
        logic        d_we;
        logic [31:0] if_addr;
        logic [31:0] d_addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mrd;
        logic        exp_d;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_be = '0;

    // index 0: MEM_LATENCY=2, index 1: MEM_LATENCY=1; inputs are shared
    logic        if_ready [2], if_rvalid [2], d_ready [2], d_rvalid [2];
    logic        mem_en [2], mem_we [2], busy [2];
    logic [31:0] if_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2];
    logic [3:0]  mem_be [2];

    logic [31:0] exp_ifrd [2];
    logic [31:0] exp_drd [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .MAX_D_STREAK(4)) u0 (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready[0]),
        .o_if_rvalid(if_rvalid[0]), .o_if_rdata(if_rdata[0]),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_be(d_be), .o_d_ready(d_ready[0]), .o_d_rvalid(d_rvalid[0]),
        .o_d_rdata(d_rdata[0]),
        .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
        .o_mem_wdata(mem_wdata[0]), .o_mem_be(mem_be[0]), .i_mem_rdata(mem_rdata),
        .o_busy(busy[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_D_STREAK(4)) u1 (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready[1]),
        .o_if_rvalid(if_rvalid[1]), .o_if_rdata(if_rdata[1]),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_be(d_be), .o_d_ready(d_ready[1]), .o_d_rvalid(d_rvalid[1]),
        .o_d_rdata(d_rdata[1]),
        .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
        .o_mem_wdata(mem_wdata[1]), .o_mem_be(mem_be[1]), .i_mem_rdata(mem_rdata),
        .o_busy(busy[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic we,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input logic [3:0] be,
                                input logic [31:0] mrd, input logic ed);
        vec_t v;
        v.if_req = ir; v.d_req = dr; v.d_we = we; v.if_addr = ia; v.d_addr = da;
        v.wdata = wd; v.be = be; v.mrd = mrd; v.exp_d = ed;
        return v;
    endfunction

    // Asynchronous reset pulse; returns at posedge+1 of the first free cycle.
    task automatic do_reset();
        rst = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
        for (int k = 0; k < 2; k++) begin exp_ifrd[k] = '0; exp_drd[k] = '0; end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance k, starting at posedge+1 of the IDLE
    // accept cycle T and returning at posedge+1 of cycle T+ml+3.
    task automatic run_row(input int k, input vec_t v, input int ml, input string nm);
        logic [31:0] ea;
        ea = v.exp_d ? v.d_addr : v.if_addr;
        if_req = v.if_req; d_req = v.d_req; d_we = v.d_we;
        if_addr = v.if_addr; d_addr = v.d_addr; d_wdata = v.wdata; d_be = v.be;
        mem_rdata = GARB;
        @(negedge clk);
        chk({nm, " if_ready@T"}, 64'(if_ready[k]), 64'(!v.exp_d));
        chk({nm, " d_ready@T"}, 64'(d_ready[k]), 64'(v.exp_d));
        chk({nm, " busy@T"}, 64'(busy[k]), 64'(0));
        @(posedge clk); #1;
        // requester inputs change after accept and must not reach the memory
        if_addr = 32'hFFFF_0000; d_addr = 32'hEEEE_0000;
        d_wdata = ~v.wdata; d_be = ~v.be; d_we = ~v.d_we;
        @(negedge clk);
        chk({nm, " mem_en@T+1"}, 64'(mem_en[k]), 64'(1));
        chk({nm, " mem_we@T+1"}, 64'(mem_we[k]), 64'(v.exp_d & v.d_we));
        chk({nm, " mem_addr@T+1"}, 64'(mem_addr[k]), 64'(ea));
        if (v.exp_d && v.d_we) begin
            chk({nm, " mem_wdata@T+1"}, 64'(mem_wdata[k]), 64'(v.wdata));
            chk({nm, " mem_be@T+1"}, 64'(mem_be[k]), 64'(v.be));
        end
        for (int c = 2; c <= ml + 1; c++) begin
            @(posedge clk); #1;
            mem_rdata = (c == ml + 1) ? v.mrd : GARB;
            @(negedge clk);
            chk($sformatf("%s mem_en@T+%0d", nm, c), 64'(mem_en[k]), 64'(0));
            chk($sformatf("%s busy@T+%0d", nm, c), 64'(busy[k]), 64'(1));
        end
        @(posedge clk); #1;
        mem_rdata = GARB;
        if (!v.exp_d) exp_ifrd[k] = v.mrd;
        else if (!v.d_we) exp_drd[k] = v.mrd;
        @(negedge clk);
        chk({nm, " if_rvalid@RESP"}, 64'(if_rvalid[k]), 64'(!v.exp_d));
        chk({nm, " d_rvalid@RESP"}, 64'(d_rvalid[k]), 64'(v.exp_d));
        chk({nm, " if_rdata@RESP"}, 64'(if_rdata[k]), 64'(exp_ifrd[k]));
        chk({nm, " d_rdata@RESP"}, 64'(d_rdata[k]), 64'(exp_drd[k]));
        @(posedge clk); #1;
    endtask

    vec_t tbl [13];

    initial begin
        int en_cnt;
        int rv_cnt;
        int wait_cyc;

        tbl[0] = mk(1, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 32'h0050_0093, 0);
        tbl[1] = mk(0, 1, 1, 32'h0, 32'h200, 32'hDEAD_BEEF, 4'b1111, 32'h5555_5555, 1);
        tbl[2] = mk(0, 1, 0, 32'h0, 32'h204, 32'h0, 4'b0011, 32'hCAFE_F00D, 1);
        // both held high: D,D,D,D,IF,D,D,D,D,IF; IF row carries d_we=1
        for (int i = 0; i < 10; i++) begin
            tbl[3 + i] = mk(1, 1, (i == 4) ? 1'b1 : 1'(i % 2),
                            32'h300 + 32'(4 * i), 32'h400 + 32'(4 * i),
                            32'h1000 + 32'(i), 4'hF, 32'hA000_0000 + 32'(i),
                            !(i == 4 || i == 9));
        end

        // reset state
        for (int k = 0; k < 2; k++) begin exp_ifrd[k] = '0; exp_drd[k] = '0; end
        #3;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d busy", k), 64'(busy[k]), 64'(0));
            chk($sformatf("rst%0d mem_en", k), 64'(mem_en[k]), 64'(0));
            chk($sformatf("rst%0d mem_we", k), 64'(mem_we[k]), 64'(0));
            chk($sformatf("rst%0d mem_addr", k), 64'(mem_addr[k]), 64'(0));
            chk($sformatf("rst%0d rvalid", k), 64'({if_rvalid[k], d_rvalid[k]}), 64'(0));
            chk($sformatf("rst%0d rdata", k), {if_rdata[k], d_rdata[k]}, 64'(0));
            chk($sformatf("rst%0d ready", k), 64'({if_ready[k], d_ready[k]}), 64'(0));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // table: single requesters, then contention with streak limit
        for (int i = 0; i < 13; i++) run_row(0, tbl[i], 2, $sformatf("row%0d", i));

        // asynchronous reset during WAIT of a fetch
        if_req = 1'b1; d_req = 1'b0; if_addr = 32'h500; mem_rdata = GARB;
        @(negedge clk);
        chk("rw accept", 64'(if_ready[0]), 64'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst = 1'b0;
        #1;
        chk("rw busy", 64'(busy[0]), 64'(0));
        chk("rw mem_en", 64'(mem_en[0]), 64'(0));
        chk("rw if_rvalid", 64'(if_rvalid[0]), 64'(0));
        chk("rw if_rdata", 64'(if_rdata[0]), 64'(0));
        if_req = 1'b0;
        mem_rdata = 32'h1234_1234;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rv_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if_rvalid[0] || d_rvalid[0] || busy[0]) rv_cnt++;
        end
        chk("rw no rvalid after release", 64'(rv_cnt), 64'(0));
        rst = 1'b0;
        if_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw ready first cycle", 64'(if_ready[0]), 64'(1));
        @(posedge clk); #1;
        chk("rw accepted", 64'(busy[0]), 64'(1));

        // MEM_LATENCY=1 load, address changed after accept
        do_reset();
        run_row(1, mk(0, 1, 0, 32'h0, 32'h10, 32'h0, 4'hF, 32'h1234_5678, 1), 1, "ml1");
        d_req = 1'b0; if_req = 1'b0;
        wait_cyc = 0;
        while ((busy[0] || busy[1]) && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("ml1 settle timeout", 64'(wait_cyc < 20), 64'(1));

        // if_req pulse while busy is ignored
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mem_rdata = 32'h0000_0077;
        @(negedge clk);
        chk("bp d accept", 64'(d_ready[0]), 64'(1));
        @(posedge clk); #1;
        d_req = 1'b0;
        en_cnt = 0;
        rv_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            if_req = (c == 2);
            @(negedge clk);
            if (c == 2) chk("bp if_ready busy", 64'(if_ready[0]), 64'(0));
            if (c == 4) chk("bp d_rvalid", 64'(d_rvalid[0]), 64'(1));
            if (c >= 5) chk($sformatf("bp idle c%0d", c), 64'(busy[0]), 64'(0));
            if (mem_en[0]) en_cnt++;
            if (if_rvalid[0]) rv_cnt++;
            @(posedge clk); #1;
        end
        chk("bp mem_en count", 64'(en_cnt), 64'(1));
        chk("bp if_rvalid count", 64'(rv_cnt), 64'(0));
        chk("bp d_rdata", 64'(d_rdata[0]), 64'(32'h77));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (D) of the RISC-V core.
- Holds exactly one transaction outstanding at a time.
- Data accesses have priority over fetches. A streak limit guarantees that fetch cannot starve.
- The block sequences the memory's fixed-latency protocol and returns read data through a registered valid/data handshake.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid. Must be >= 1.
- MAX_D_STREAK, 4, maximum number of consecutive D grants while if_req is pending. Must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  fetch accepted this cycle when if_req is also 1.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; completion for loads and stores.
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  a transaction is in flight (state is not IDLE).

Behaviour:
- States:
  - IDLE: the only state in which if_ready or d_ready can be 1.
  - ISSUE: mem_en = 1 for exactly one cycle.
  - WAIT: counts MEM_LATENCY cycles.
  - RESP: the rvalid pulse for the owner.
- Arbitration in IDLE (combinational):
  - If d_req and not (if_req and streak == MAX_D_STREAK), grant D.
  - Else if if_req, grant IF.
  - The winner's ready = 1; the loser's ready = 0.
  - Accept = req & ready.
- Streak counter:
  - Increments on a D accept, saturating at MAX_D_STREAK.
  - Clears on an IF accept.
  - Clears on a D accept when if_req = 0.
- On accept at cycle T:
  - Capture owner, address, we, wdata and be into registers. Requester inputs are ignored after T.
  - Move to ISSUE.
- T+1 (ISSUE):
  - mem_en = 1; mem_we/addr/wdata/be come from the captured registers.
  - mem_we = 0 for IF.
  - Move to WAIT with the counter loaded to MEM_LATENCY-1.
- WAIT:
  - Decrement each cycle.
  - At count 0 (cycle T+1+MEM_LATENCY), sample mem_rdata into the owner's rdata register (loads/fetches only) and move to RESP.
- RESP (cycle T+2+MEM_LATENCY):
  - The owner's rvalid = 1 for one cycle.
  - Next state IDLE.
  - A new accept can occur at T+3+MEM_LATENCY, giving back-to-back throughput of one transaction per MEM_LATENCY+3 cycles.
- Store completion: d_rvalid pulses at the same timing as a load; d_rdata keeps its previous value.
- Output register behaviour:
  - if_rdata and d_rdata hold their value until the next completing read of that port.
  - mem_* outputs other than mem_en are don't-care when mem_en = 0, but are driven from registers; they are not combinational from the inputs.
- A req deasserted before accept has no effect. No request is queued.
- Simultaneous if_req and d_req in IDLE: resolved by the priority rule above. The loser sees ready = 0 and must hold its req.
- Requests during ISSUE, WAIT or RESP are ignored: ready = 0 and nothing is latched.
- Reset (asynchronous, rst = 0), in any state:
  - State = IDLE; streak = 0; counter = 0.
  - All outputs = 0, including the rdata registers.
  - An in-flight memory result is discarded and no rvalid is produced.
  - First accept is possible in the first cycle after rst rises with a request present.

Decomposition:
- Shared package riscv_mem_pkg:
  - State enum (IDLE, ISSUE, WAIT, RESP).
  - Owner encoding constants (OWN_IF = 0, OWN_D = 1).
  - Default widths.
- One natural sub-module, mem_arb_pick: combinational winner selection from d_req, if_req, streak and MAX_D_STREAK, producing grant_if/grant_d.
- FSM, counters and capture registers stay in the top.

Test Plan:
- IF only, MEM_LATENCY=2, if_addr=0x100, memory returns 0x00500093:
  - if_ready=1 at T; mem_en=1, mem_addr=0x100 at T+1; if_rvalid=1, if_rdata=0x00500093 at T+4.
- D store d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b1111:
  - mem_we=1 with those values at T+1; d_rvalid at T+4; d_rdata unchanged.
- if_req and d_req both held high continuously, MAX_D_STREAK=4:
  - Grant order D,D,D,D,IF,D,D,D,D,IF; accepts spaced exactly 5 cycles apart.
- MEM_LATENCY=1, D load from 0x10 returning 0x12345678:
  - d_rvalid=1, d_rdata=0x12345678 at T+3.
  - Changing d_addr at T+1 does not alter mem_addr.
- Assert rst=0 during WAIT of an IF read:
  - busy, mem_en, if_rvalid and if_rdata = 0 immediately (asynchronous).
  - No rvalid after release; a new if_req is accepted in the first cycle after release.
- if_req pulses for one cycle while the block is busy:
  - No accept, no memory access; busy returns to 0 after the current RESP.
